// File: rtl/serial_byte_source_pkg.sv
// Shared types and constants for the serial byte source and its byte FIFO.
package serial_byte_source_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_byte_source_byte_fifo.sv
// Byte FIFO with registered full/empty/level; head entry is read straight from storage.
module byte_fifo
    import serial_byte_source_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_n;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        level_n = level;
        if (push && !pop) begin
            level_n = level + LW'(1);
        end else if (pop && !push) begin
            level_n = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_n;
            full  <= (level_n == LW'(DEPTH));
            empty <= (level_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/serial_byte_source.sv
// Buffers bytes from a valid/ready port and shifts them out MSB first, one bit per clock.
module serial_byte_source
    import serial_byte_source_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic        IDLE_LEVEL = 1'b0,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              sdout,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              byte_done,
    output logic              busy,
    output logic [LW-1:0]     level
);

    state_t                 state, state_n;
    logic [BYTE_W-1:0]      shreg, shreg_n;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [GAP_CNT_W-1:0]   gap_cnt, gap_cnt_n;
    logic                   sdout_n, bit_valid_n, frame_start_n, byte_done_n, busy_n;
    logic                   next_byte;
    logic                   push, pop;
    logic                   full, empty;
    logic [BYTE_W-1:0]      head;

    assign in_ready = !full;
    assign push     = in_valid && !full;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            sdout       <= IDLE_LEVEL;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            byte_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            gap_cnt     <= gap_cnt_n;
            sdout       <= sdout_n;
            bit_valid   <= bit_valid_n;
            frame_start <= frame_start_n;
            byte_done   <= byte_done_n;
            busy        <= busy_n;
        end
    end

    // Serializer: next_byte marks the points where the head byte may be taken.
    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        bit_cnt_n     = bit_cnt;
        gap_cnt_n     = gap_cnt;
        sdout_n       = IDLE_LEVEL;
        bit_valid_n   = 1'b0;
        frame_start_n = 1'b0;
        byte_done_n   = 1'b0;
        next_byte     = 1'b0;
        pop           = 1'b0;

        case (state)
            ST_IDLE: begin
                next_byte = 1'b1;
            end
            ST_SHIFT: begin
                if (bit_cnt != '0) begin
                    bit_cnt_n   = bit_cnt - BIT_CNT_W'(1);
                    sdout_n     = shreg[bit_cnt_n];
                    bit_valid_n = 1'b1;
                    byte_done_n = (bit_cnt_n == '0);
                end else if (GAP_CYCLES != 0) begin
                    state_n   = ST_GAP;
                    gap_cnt_n = GAP_CNT_W'(GAP_CYCLES - 1);
                end else begin
                    next_byte = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_n = gap_cnt - GAP_CNT_W'(1);
                end else begin
                    next_byte = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (next_byte) begin
            if (!empty) begin
                pop           = 1'b1;
                shreg_n       = head;
                bit_cnt_n     = BIT_CNT_W'(BYTE_W - 1);
                sdout_n       = head[BYTE_W-1];
                bit_valid_n   = 1'b1;
                frame_start_n = 1'b1;
                state_n       = ST_SHIFT;
            end else begin
                state_n = ST_IDLE;
            end
        end

        // A pop only happens on the way into SHIFT, so staying idle means no byte left this edge.
        busy_n = (state_n != ST_IDLE) || !empty || push;
    end

endmodule

// File: tb/tb_serial_byte_source.sv
// Self-checking bench for serial_byte_source: directed scenarios plus randomized traffic vs. a queue model.
module tb_serial_byte_source;

    localparam int unsigned LW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v0, rdy0, sd0, bv0, fs0, bd0, busy0;
    logic [7:0]    d0;
    logic [LW-1:0] lvl0;
    logic          v3, rdy3, sd3, bv3, fs3, bd3, busy3;
    logic [7:0]    d3;
    logic [LW-1:0] lvl3;

    int vectors     = 0;
    int miscompares = 0;

    serial_byte_source #(.DEPTH(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
        .sdout(sd0), .bit_valid(bv0), .frame_start(fs0), .byte_done(bd0),
        .busy(busy0), .level(lvl0)
    );

    serial_byte_source #(.DEPTH(4), .GAP_CYCLES(3), .IDLE_LEVEL(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .sdout(sd3), .bit_valid(bv3), .frame_start(fs3), .byte_done(bd3),
        .busy(busy3), .level(lvl3)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v0 = 1'b0; d0 = '0; v3 = 1'b0; d3 = '0;
        tick(); tick();
        vectors++;
        if ({rdy0, sd0, bv0, fs0, bd0, busy0, lvl0} !== {1'b1, 5'b00000, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_dut0: got %b expected %b", {rdy0, sd0, bv0, fs0, bd0, busy0, lvl0}, 9'b100000000);
        end
        vectors++;
        if ({rdy3, sd3, bv3, fs3, bd3, busy3, lvl3} !== {2'b11, 4'b0000, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_dut3: got %b expected %b", {rdy3, sd3, bv3, fs3, bd3, busy3, lvl3}, 9'b110000000);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        logic [7:0] b, got;
        b = 8'd47; got = '0;
        v0 = 1'b1; d0 = b;
        tick();
        v0 = 1'b0;
        vectors++;
        if ({lvl0, busy0, bv0} !== {3'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_enqueue: got %b expected %b", {lvl0, busy0, bv0}, 5'b00110);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if ({sd0, bv0, fs0, bd0} !== {b[7-i], 1'b1, (i == 0), (i == 7)}) begin
                miscompares++;
                $display("FAIL single_bit%0d: got %b expected %b", i, {sd0, bv0, fs0, bd0},
                         {b[7-i], 1'b1, (i == 0), (i == 7)});
            end
            got = {got[6:0], sd0};
        end
        vectors++;
        if (got !== 8'd47) begin
            miscompares++;
            $display("FAIL single_value: got %0d expected 47", got);
        end
        tick();
        vectors++;
        if ({sd0, bv0, busy0, lvl0} !== {3'b000, 3'd0}) begin
            miscompares++;
            $display("FAIL single_idle: got %b expected 000000", {sd0, bv0, busy0, lvl0});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [4];
        logic [31:0] stream;
        int nbits, holes, maxlvl, drops;
        bytes[0] = 8'd47; bytes[1] = 8'd111; bytes[2] = 8'd175; bytes[3] = 8'd239;
        stream = '0; nbits = 0; holes = 0; maxlvl = 0; drops = 0;
        v0 = 1'b1; d0 = bytes[0];
        tick();
        v0 = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if ((c % 8 == 0) && (c < 32)) begin
                v0 = 1'b1; d0 = bytes[c/8];
            end
            tick();
            v0 = 1'b0;
            if (bv0) begin
                stream = {stream[30:0], sd0};
                nbits++;
            end else if (c <= 32) begin
                holes++;
            end
            if (int'(lvl0) > maxlvl) maxlvl = int'(lvl0);
            if (!rdy0) drops++;
        end
        vectors++;
        if (nbits != 32 || holes != 0) begin
            miscompares++;
            $display("FAIL b2b_contiguous: got bits=%0d holes=%0d expected bits=32 holes=0", nbits, holes);
        end
        vectors++;
        if (stream !== {bytes[0], bytes[1], bytes[2], bytes[3]}) begin
            miscompares++;
            $display("FAIL b2b_stream: got %h expected %h", stream, {bytes[0], bytes[1], bytes[2], bytes[3]});
        end
        vectors++;
        if (maxlvl > 2 || drops != 0) begin
            miscompares++;
            $display("FAIL b2b_level_ready: got maxlvl=%0d drops=%0d expected maxlvl<=2 drops=0", maxlvl, drops);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] fb [6];
        logic [7:0] cap [$];
        logic [7:0] sh;
        logic       take;
        int idx, nb, saw_full;
        for (int i = 0; i < 6; i++) fb[i] = 8'($urandom);
        idx = 0; nb = 0; saw_full = 0; sh = '0;
        for (int c = 0; c < 150 && nb < 48; c++) begin
            v0 = (idx < 6);
            d0 = (idx < 6) ? fb[idx] : 8'h00;
            take = v0 && rdy0;
            tick();
            if (take) idx++;
            vectors++;
            if (rdy0 !== (lvl0 != 3'd4)) begin
                miscompares++;
                $display("FAIL full_ready c%0d: got ready=%b expected %b at level %0d", c, rdy0, (lvl0 != 3'd4), lvl0);
            end
            if (lvl0 == 3'd4) saw_full = 1;
            if (bv0) begin
                sh = {sh[6:0], sd0};
                nb++;
                if (nb % 8 == 0) cap.push_back(sh);
            end
        end
        v0 = 1'b0;
        vectors++;
        if (idx != 6 || saw_full != 1 || cap.size() != 6) begin
            miscompares++;
            $display("FAIL full_counts: got pushed=%0d full=%0d bytes=%0d expected 6 1 6", idx, saw_full, cap.size());
        end
        for (int i = 0; i < 6 && i < cap.size(); i++) begin
            vectors++;
            if (cap[i] !== fb[i]) begin
                miscompares++;
                $display("FAIL full_order%0d: got %h expected %h", i, cap[i], fb[i]);
            end
        end
        tick();
    endtask

    task automatic test_gap();
        logic [7:0] a, b;
        logic       eb, es, ef;
        a = 8'd63; b = 8'd191;
        v3 = 1'b1; d3 = a;
        tick();
        d3 = b;
        for (int k = 1; k <= 20; k++) begin
            tick();
            v3 = 1'b0;
            if (k <= 8) begin
                eb = 1'b1; es = a[8-k]; ef = (k == 1);
            end else if (k <= 11) begin
                eb = 1'b0; es = 1'b1; ef = 1'b0;
            end else if (k <= 19) begin
                eb = 1'b1; es = b[19-k]; ef = (k == 12);
            end else begin
                eb = 1'b0; es = 1'b1; ef = 1'b0;
            end
            vectors++;
            if ({sd3, bv3, fs3} !== {es, eb, ef}) begin
                miscompares++;
                $display("FAIL gap_cycle%0d: got %b expected %b", k, {sd3, bv3, fs3}, {es, eb, ef});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a, b, c, d;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
        v0 = 1'b1; d0 = a; tick();
        d0 = b; tick();
        d0 = c; tick();
        v0 = 1'b0; tick(); tick();
        vectors++;
        if ({sd0, bv0, lvl0} !== {a[4], 1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL midrst_before: got %b expected %b", {sd0, bv0, lvl0}, {a[4], 1'b1, 3'd2});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({sd0, bv0, busy0, rdy0, fs0, bd0, lvl0} !== {6'b000100, 3'd0}) begin
            miscompares++;
            $display("FAIL midrst_after: got %b expected 000100000", {sd0, bv0, busy0, rdy0, fs0, bd0, lvl0});
        end
        v0 = 1'b1; d0 = d;
        tick();
        v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if ({sd0, bv0, fs0} !== {d[7-i], 1'b1, (i == 0)}) begin
                miscompares++;
                $display("FAIL midrst_bit%0d: got %b expected %b", i, {sd0, bv0, fs0}, {d[7-i], 1'b1, (i == 0)});
            end
        end
        tick();
        vectors++;
        if ({bv0, busy0, lvl0} !== {2'b00, 3'd0}) begin
            miscompares++;
            $display("FAIL midrst_drained: got %b expected 00000", {bv0, busy0, lvl0});
        end
    endtask

    task automatic test_push_pop_level();
        logic [7:0] pb [5];
        logic [7:0] cap [$];
        logic [7:0] sh;
        int nb;
        for (int i = 0; i < 5; i++) pb[i] = 8'($urandom);
        nb = 0; sh = '0;
        for (int c = 0; c <= 45; c++) begin
            v0 = (c < 4) || (c == 9);
            d0 = (c < 4) ? pb[c] : pb[4];
            tick();
            if (c == 3 || c == 8 || c == 9 || c == 10) begin
                vectors++;
                if ({lvl0, rdy0} !== {3'd3, 1'b1}) begin
                    miscompares++;
                    $display("FAIL pushpop_level c%0d: got lvl=%0d rdy=%b expected lvl=3 rdy=1", c, lvl0, rdy0);
                end
            end
            if (c == 9) begin
                vectors++;
                if (fs0 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pushpop_popedge: got frame_start=%b expected 1", fs0);
                end
            end
            if (bv0) begin
                sh = {sh[6:0], sd0};
                nb++;
                if (nb % 8 == 0) cap.push_back(sh);
            end
        end
        v0 = 1'b0;
        vectors++;
        if (cap.size() != 5) begin
            miscompares++;
            $display("FAIL pushpop_count: got %0d bytes expected 5", cap.size());
        end
        for (int i = 0; i < 5 && i < cap.size(); i++) begin
            vectors++;
            if (cap[i] !== pb[i]) begin
                miscompares++;
                $display("FAIL pushpop_order%0d: got %h expected %h", i, cap[i], pb[i]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] expq [$];
        logic [7:0] sh, exp_b;
        logic       take;
        int lvl_m, nb, drain;
        lvl_m = 0; nb = 0; sh = '0;
        for (int c = 0; c < 400; c++) begin
            v0 = ($urandom_range(0, 9) < 3);
            d0 = 8'($urandom);
            take = v0 && rdy0;
            tick();
            if (take) begin
                expq.push_back(d0);
                lvl_m++;
            end
            if (fs0) lvl_m--;
            vectors++;
            if ({lvl0, rdy0} !== {3'(lvl_m), (lvl_m < 4)}) begin
                miscompares++;
                $display("FAIL rand_level c%0d: got lvl=%0d rdy=%b expected lvl=%0d rdy=%b", c, lvl0, rdy0, lvl_m, (lvl_m < 4));
            end
            if (bv0) begin
                vectors++;
                if ({fs0, bd0} !== {(nb % 8 == 0), (nb % 8 == 7)}) begin
                    miscompares++;
                    $display("FAIL rand_marks c%0d: got %b expected %b", c, {fs0, bd0}, {(nb % 8 == 0), (nb % 8 == 7)});
                end
                sh = {sh[6:0], sd0};
                nb++;
                if (nb % 8 == 0) begin
                    exp_b = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                    vectors++;
                    if (sh !== exp_b) begin
                        miscompares++;
                        $display("FAIL rand_byte%0d: got %h expected %h", nb / 8, sh, exp_b);
                    end
                end
            end else begin
                vectors++;
                if (sd0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_idle_level c%0d: got %b expected 0", c, sd0);
                end
            end
        end
        v0 = 1'b0;
        drain = 0;
        while (busy0 && drain < 100) begin
            tick();
            if (bv0) begin
                sh = {sh[6:0], sd0};
                nb++;
                if (nb % 8 == 0) begin
                    exp_b = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                    vectors++;
                    if (sh !== exp_b) begin
                        miscompares++;
                        $display("FAIL rand_drain_byte%0d: got %h expected %h", nb / 8, sh, exp_b);
                    end
                end
            end
            drain++;
        end
        vectors++;
        if (busy0 !== 1'b0 || expq.size() != 0 || nb % 8 != 0) begin
            miscompares++;
            $display("FAIL rand_drain: got busy=%b left=%0d partial=%0d expected 0 0 0", busy0, expq.size(), nb % 8);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_gap();
        test_reset_mid();
        test_push_pop_level();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
